// File: rtl/imem_loader.sv
// Boot/run controller: packs a byte stream little-endian into 32-bit words, writes them
// into instruction RAM from address 0, and gates the core reset. Optional: LOADER_CHECKSUM_EN.
module imem_loader #(
  parameter int ADDR_W = 12,
  parameter int DEPTH  = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_req,
  input  logic              run_req,
  input  logic              halt_req,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_rst_n,
  output logic [ADDR_W:0]   word_count,
  output logic [2:0]        state,
  output logic              err,
  output logic [31:0]       checksum
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    FLUSH = 3'd2,
    RUN   = 3'd3,
    HALT  = 3'd4
  } state_t;

  localparam logic [ADDR_W:0] FULL = (ADDR_W+1)'(DEPTH);

  state_t            st, nxt;
  logic [1:0]        lane;
  logic [31:0]       pack, merged;
  logic              accept, wr, restart, full;
  logic [ADDR_W:0]   nxt_count;

  assign full   = (word_count == FULL);
  assign accept = byte_valid && byte_ready;
  assign state  = st;

  // Partial word plus any byte accepted this cycle; unfilled lanes stay zero.
  always_comb begin
    merged = pack;
    if (accept) merged[{lane, 3'b000} +: 8] = byte_data;
  end

  always_comb begin
    nxt     = st;
    wr      = 1'b0;
    restart = 1'b0;
    case (st)
      IDLE: begin
        if (run_req) begin
          if (word_count != '0) nxt = RUN;
        end else if (load_req) begin
          nxt     = LOAD;
          restart = 1'b1;
        end
      end
      LOAD: begin
        if (halt_req) begin
          nxt = HALT;
        end else if (run_req) begin
          // Any pending bytes (including one arriving now) are written while in FLUSH.
          if (lane != 2'd0 || accept) begin
            nxt = FLUSH;
            wr  = 1'b1;
          end else if (word_count != '0) begin
            nxt = RUN;
          end else begin
            nxt = IDLE;
          end
        end else if (load_req) begin
          restart = 1'b1;
        end else if (accept && lane == 2'd3) begin
          wr = 1'b1;
        end
      end
      FLUSH: nxt = RUN;
      RUN: begin
        if (halt_req) begin
          nxt = HALT;
        end else if (load_req) begin
          nxt     = LOAD;
          restart = 1'b1;
        end
      end
      HALT: begin
        if (!halt_req) begin
          if (run_req) begin
            nxt = RUN;
          end else if (load_req) begin
            nxt     = LOAD;
            restart = 1'b1;
          end
        end
      end
      default: nxt = IDLE;
    endcase
    nxt_count = restart ? '0 : word_count + (ADDR_W+1)'(wr);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st         <= IDLE;
      cpu_rst_n  <= 1'b0;
      byte_ready <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      word_count <= '0;
      err        <= 1'b0;
      lane       <= 2'd0;
      pack       <= '0;
    end else begin
      st         <= nxt;
      imem_we    <= wr;
      word_count <= nxt_count;
      if (wr) begin
        imem_addr  <= word_count[ADDR_W-1:0];
        imem_wdata <= merged;
      end
      if (restart || wr || nxt != LOAD) begin
        lane <= 2'd0;
        pack <= '0;
      end else if (accept) begin
        lane <= lane + 2'd1;
        pack <= merged;
      end
      if (restart)
        err <= 1'b0;
      else if (st == LOAD && full && byte_valid)
        err <= 1'b1;
      byte_ready <= (nxt == LOAD) && (nxt_count != FULL);
      // Hold the core in reset for the first RUN cycle so fetch restarts cleanly.
      cpu_rst_n  <= (st == RUN) && (nxt == RUN);
    end
  end

`ifdef LOADER_CHECKSUM_EN
  logic [31:0] csum;
  always_ff @(posedge clk) begin
    if (rst || restart) csum <= '0;
    else if (wr)        csum <= csum + merged;
  end
  assign checksum = csum;
`else
  assign checksum = 32'd0;
`endif

endmodule

// File: tb/tb_imem_loader.sv
// Directed + randomized bench for imem_loader; expected RAM image, counts and checksum
// are derived from the byte stream by a simple packing model.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst, load_req, run_req, halt_req, byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready, imem_we, cpu_rst_n, err;
  logic [11:0] imem_addr;
  logic [31:0] imem_wdata, checksum;
  logic [12:0] word_count;
  logic [2:0]  state;

  imem_loader #(.ADDR_W(12), .DEPTH(4096)) dut (
    .clk(clk), .rst(rst), .load_req(load_req), .run_req(run_req), .halt_req(halt_req),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .cpu_rst_n(cpu_rst_n), .word_count(word_count), .state(state), .err(err),
    .checksum(checksum)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          wr_cnt = 0;
  logic [11:0] last_addr = '0;
  logic [31:0] dram [4096];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // RAM write observer: mirrors every write into a local image.
  always @(negedge clk) begin
    if (!rst && imem_we === 1'b1) begin
      dram[imem_addr] = imem_wdata;
      wr_cnt++;
      last_addr = imem_addr;
      chk("we_state", 64'(state == 3'd1 || state == 3'd2), 64'd1);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic ld, input logic rn, input logic ht);
    load_req = ld; run_req = rn; halt_req = ht;
    step();
    load_req = 1'b0; run_req = 1'b0; halt_req = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int bound = 0;
    byte_valid = 1'b1;
    byte_data  = b;
    while (byte_ready !== 1'b1 && bound < 50) begin
      step();
      bound++;
    end
    if (bound >= 50) chk("ready_timeout", 64'(byte_ready), 64'd1);
    step();
    byte_valid = 1'b0;
    byte_data  = 8'($urandom);
    repeat ($urandom_range(0, 2)) step();
  endtask

  task automatic expect_run(input bit partial);
    if (partial) begin
      chk("flush_state", 64'(state), 64'd2);
      chk("flush_we", 64'(imem_we), 64'd1);
      step();
    end
    chk("run_state", 64'(state), 64'd3);
    chk("run_entry_rst_n", 64'(cpu_rst_n), 64'd0);
    step();
    chk("run_rst_n", 64'(cpu_rst_n), 64'd1);
  endtask

  task automatic load_and_run(input logic [7:0] q[$], input string tag);
    int w0 = wr_cnt;
    int nw = (q.size() + 3) / 4;
    int bad = 0;
    logic [31:0] sum = '0;
    logic [31:0] exp_ck;
    pulse(1'b1, 1'b0, 1'b0);
    chk({tag, "_load_state"}, 64'(state), 64'd1);
    foreach (q[i]) send_byte(q[i]);
    pulse(1'b0, 1'b1, 1'b0);
    expect_run((q.size() % 4) != 0);
    chk({tag, "_count"}, 64'(word_count), 64'(nw));
    chk({tag, "_writes"}, 64'(wr_cnt - w0), 64'(nw));
    for (int w = 0; w < nw; w++) begin
      logic [31:0] exp = '0;
      for (int k = 0; k < 4; k++)
        if (4*w + k < q.size()) exp = exp + (32'(q[4*w + k]) << (8*k));
      sum = sum + exp;
      if (dram[w] !== exp) bad++;
    end
    chk({tag, "_words_bad"}, 64'(bad), 64'd0);
`ifdef LOADER_CHECKSUM_EN
    exp_ck = sum;
`else
    exp_ck = 32'd0;
`endif
    chk({tag, "_checksum"}, 64'(checksum), 64'(exp_ck));
    chk({tag, "_err"}, 64'(err), 64'd0);
  endtask

  function automatic logic [7:0] pat(input int k);
    return 8'((k * 37) + (k >> 8));
  endfunction

  initial begin
    logic [7:0] q[$];
    int w0, k, cyc, bad;
    rst = 1'b1; load_req = 1'b0; run_req = 1'b0; halt_req = 1'b0;
    byte_valid = 1'b0; byte_data = 8'h00;
    step(); step();
    chk("rst_state", 64'(state), 64'd0);
    chk("rst_cpu_rst_n", 64'(cpu_rst_n), 64'd0);
    chk("rst_byte_ready", 64'(byte_ready), 64'd0);
    chk("rst_we", 64'(imem_we), 64'd0);
    chk("rst_addr", 64'(imem_addr), 64'd0);
    chk("rst_wdata", 64'(imem_wdata), 64'd0);
    chk("rst_count", 64'(word_count), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_checksum", 64'(checksum), 64'd0);
    rst = 1'b0;
    step();

    // run_req with nothing loaded is ignored
    w0 = wr_cnt;
    pulse(1'b0, 1'b1, 1'b0);
    step();
    chk("idle_run_state", 64'(state), 64'd0);
    chk("idle_run_rst_n", 64'(cpu_rst_n), 64'd0);
    chk("idle_run_writes", 64'(wr_cnt - w0), 64'd0);

    q = '{8'h13, 8'h05, 8'h50, 8'h00};
    load_and_run(q, "li");
    chk("li_word0", 64'(dram[0]), 64'h00500513);

    // halt has priority over run; restart leaves RAM alone
    w0 = wr_cnt;
    pulse(1'b0, 1'b1, 1'b1);
    chk("halt_state", 64'(state), 64'd4);
    chk("halt_rst_n", 64'(cpu_rst_n), 64'd0);
    repeat (3) step();
    pulse(1'b0, 1'b1, 1'b0);
    expect_run(1'b0);
    chk("halt_run_writes", 64'(wr_cnt - w0), 64'd0);
    chk("halt_run_count", 64'(word_count), 64'd1);
    chk("halt_run_word0", 64'(dram[0]), 64'h00500513);

    q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    load_and_run(q, "six");
    chk("six_word0", 64'(dram[0]), 64'h04030201);
    chk("six_word1", 64'(dram[1]), 64'h00000605);

    for (int r = 0; r < 4; r++) begin
      int n = $urandom_range(1, 40);
      q = {};
      for (int i = 0; i < n; i++) q.push_back(8'($urandom));
      load_and_run(q, $sformatf("rnd%0d", r));
    end

    q = '{8'h01, 8'h00, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    load_and_run(q, "ck");

    // reset mid-word: no write, back to idle
    pulse(1'b1, 1'b0, 1'b0);
    send_byte(8'hAA);
    send_byte(8'hBB);
    w0 = wr_cnt;
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_state", 64'(state), 64'd0);
    chk("mid_rst_count", 64'(word_count), 64'd0);
    chk("mid_rst_ready", 64'(byte_ready), 64'd0);
    chk("mid_rst_rst_n", 64'(cpu_rst_n), 64'd0);
    chk("mid_rst_checksum", 64'(checksum), 64'd0);
    repeat (2) step();
    chk("mid_rst_writes", 64'(wr_cnt - w0), 64'd0);
    q = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
    load_and_run(q, "post_rst");
    chk("post_rst_word0", 64'(dram[0]), 64'hDEADBEEF);

    // overflow: byte_valid held high for the whole RAM and beyond
    w0 = wr_cnt;
    pulse(1'b1, 1'b0, 1'b0);
    byte_valid = 1'b1;
    k = 0; cyc = 0;
    byte_data = pat(0);
    while (k < 16384 && cyc < 20000) begin
      logic acc;
      acc = byte_ready;
      step();
      cyc++;
      if (acc) begin
        k++;
        byte_data = pat(k);
      end
    end
    chk("ovf_accepted", 64'(k), 64'd16384);
    repeat (3) step();
    chk("ovf_ready", 64'(byte_ready), 64'd0);
    chk("ovf_err", 64'(err), 64'd1);
    chk("ovf_count", 64'(word_count), 64'd4096);
    chk("ovf_writes", 64'(wr_cnt - w0), 64'd4096);
    chk("ovf_last_addr", 64'(last_addr), 64'hFFF);
    bad = 0;
    for (int i = 0; i < 4096; i++)
      if (dram[i] !== {pat(4*i+3), pat(4*i+2), pat(4*i+1), pat(4*i)}) bad++;
    chk("ovf_words_bad", 64'(bad), 64'd0);
    w0 = wr_cnt;
    repeat (5) step();
    byte_valid = 1'b0;
    step();
    chk("ovf_no_more_writes", 64'(wr_cnt - w0), 64'd0);
    chk("ovf_err_sticky", 64'(err), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
